uart_tx_ser: RTL and testbench
==============================

// Module: uart_tx_ser
// PURPOSE
// UART transmit serializer downstream of the divider control block. Accepts byte strobes
// (tx_ready/tx_data), buffers them in a small FIFO and emits 8N1 (optional parity, 1-2 stop)
// frames on uart_txd, LSB first. Bytes written back-to-back go out with no idle gap between frames.
// PARAMETERS
// CLKS_PER_BIT  5208  clk cycles per bit (50 MHz / 9600 baud); legal range >= 2
// PARITY_EN     0     1 = insert a parity bit after the data bits
// PARITY_ODD    0     1 = odd parity, 0 = even parity; used only when PARITY_EN = 1
// STOP_BITS     1     number of stop bits, 1 or 2
// FIFO_AW       2     FIFO address width; depth = 2**FIFO_AW
// PORTS
// clk           in   1  system clock, all logic on rising edge
// rst           in   1  asynchronous reset, active-low
// tx_ready      in   1  write strobe; each high cycle pushes tx_data
// tx_data       in   8  byte to transmit
// ovr_clr       in   1  synchronous clear of ovr_flag
// uart_txd      out  1  serial line; idles high
// tx_busy       out  1  high while FSM is not IDLE or FIFO is not empty
// tx_byte_done  out  1  one-cycle pulse on the last cycle of the final stop bit
// fifo_full     out  1  FIFO count == depth
// fifo_empty    out  1  FIFO count == 0
// ovr_flag      out  1  sticky flag; a push was dropped because the FIFO was full
// BEHAVIOUR
// - Reset (rst=0, async): uart_txd=1, tx_busy=0, tx_byte_done=0, fifo_full=0, fifo_empty=1, ovr_flag=0.
//   FIFO pointers and count are cleared, the FSM goes to IDLE, and counters are zeroed.
// - Push rule: accepted iff count < depth at the start of the cycle. A push while full drops the byte
//   and sets ovr_flag. If ovr_clr and a dropped push occur in the same cycle, the set wins.
// - Pop: the FSM pops when leaving IDLE or STOP with the FIFO non-empty. A push and a pop in the same
//   cycle leave count unchanged. Pointers wrap modulo depth.
// - FSM states and transitions:
//   - IDLE   -> START when the FIFO is non-empty; latches the head byte into the shift register.
//   - START  (txd=0) -> DATA.
//   - DATA   sends bit[0] first, 8 bits. Then -> PARITY if PARITY_EN, else -> STOP.
//   - PARITY sends ^byte for even parity, ~^byte for odd parity. Then -> STOP.
//   - STOP   (txd=1) lasts STOP_BITS bit-times. On its last cycle it pulses tx_byte_done.
//            Next state is START (pop same cycle) if the FIFO is non-empty, else IDLE.
// - Bit timing: each bit is held exactly CLKS_PER_BIT cycles using a baud counter running
//   0..CLKS_PER_BIT-1. The counter reloads at every bit boundary and is held at 0 in IDLE.
// - Latency: a push in cycle N into an empty FIFO with the FSM in IDLE gives uart_txd=0 from N+2.
//   Frame length is (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
// - uart_txd is registered with no glitches. A reset mid-frame forces txd high immediately and
//   discards both the partial frame and the FIFO contents.
// - tx_data is sampled only in the push cycle, so later changes do not affect a queued byte.
// TESTING (bench uses CLKS_PER_BIT=4)
// 1. Single push 0x55 -> txd low at N+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each),
//    then stop high. tx_byte_done pulses at N+41; tx_busy falls at N+42.
// 2. Pushes 0x34,0x12,0x05,0x00 on four consecutive cycles -> four contiguous 40-cycle frames
//    with no idle gap, in order, and four tx_byte_done pulses spaced 40 cycles apart.
// 3. PARITY_EN=1: 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0.
//    Frame is 44 cycles.
// 4. Overflow: six pushes on consecutive cycles (0xA0..0xA5) -> first five are sent, 0xA5 is dropped.
//    ovr_flag=1 from the cycle after the 6th push; fifo_full=1 during it. ovr_clr clears the flag.
// 5. STOP_BITS=2: single 0xFF -> stop high for 8 cycles, frame is 44 cycles, tx_byte_done at end.
// 6. rst asserted in DATA of byte 0x3C with 2 bytes queued -> txd=1 at once, fifo_empty=1,
//    tx_busy=0. After release, a fresh push 0x81 is sent normally.

Source files
------------

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: a small byte FIFO feeding a frame FSM that emits
// start, 8 data bits (LSB first), optional parity and 1-2 stop bits on uart_txd.
// Back-to-back bytes leave no idle gap because STOP hands straight over to START.
module uart_tx_ser #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       ovr_clr,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_byte_done,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       ovr_flag
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PENULT = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push;
  logic               pop;

  state_t             state;
  logic [CW-1:0]      baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               par_bit;
  logic               stop_idx;
  logic               bit_end;
  logic               stop_last;
  logic [7:0]         head;
  logic               head_par;

  // The count never exceeds DEPTH, so its top bit alone marks a full FIFO.
  assign fifo_empty = (count == '0);
  assign fifo_full  = count[FIFO_AW];
  assign push       = tx_ready && !fifo_full;

  assign bit_end    = (baud == BAUD_LAST);
  assign stop_last  = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign pop        = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && bit_end && stop_last));
  assign tx_busy    = (state != IDLE) || !fifo_empty;

  // Head byte and its parity are captured together when the FSM leaves IDLE/STOP.
  assign head       = mem[rd_ptr];
  assign head_par   = (^head) ^ (PARITY_ODD != 0);

  // FIFO storage: written only on accepted pushes, so a queued byte never changes.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a dropped push outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      ovr_flag <= 1'b0;
    else if (tx_ready && fifo_full) ovr_flag <= 1'b1;
    else if (ovr_clr)              ovr_flag <= 1'b0;
  end

  // Frame FSM with baud counter; uart_txd and tx_byte_done are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      baud         <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      stop_idx     <= 1'b0;
      uart_txd     <= 1'b1;
      tx_byte_done <= 1'b0;
    end else begin
      tx_byte_done <= (state == STOP) && stop_last && (baud == BAUD_PENULT);
      case (state)
        IDLE: begin
          baud <= '0;
          if (!fifo_empty) begin
            state    <= START;
            shreg    <= head;
            par_bit  <= head_par;
            uart_txd <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud     <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_txd <= shreg[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                state    <= PARITY;
                uart_txd <= par_bit;
              end else begin
                state    <= STOP;
                stop_idx <= 1'b0;
                uart_txd <= 1'b1;
              end
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              shreg    <= shreg >> 1;
              uart_txd <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud     <= '0;
            state    <= STOP;
            stop_idx <= 1'b0;
            uart_txd <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (!stop_last) begin
              stop_idx <= 1'b1;
            end else if (!fifo_empty) begin
              state    <= START;
              shreg    <= head;
              par_bit  <= head_par;
              uart_txd <= 1'b0;
            end else begin
              state    <= IDLE;
              uart_txd <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud     <= '0;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Testbench for uart_tx_ser: four instances (8N1, even parity, odd parity,
// two stop bits) share one stimulus stream and are compared every cycle
// against a frame-schedule model that places each accepted byte on a timeline.
module tb_uart_tx_ser;

  localparam int CPB  = 4;
  localparam int NDUT = 4;
  localparam int MAXF = 512;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            tx_ready;
  logic [7:0]      tx_data;
  logic            ovr_clr;
  logic [NDUT-1:0] txd;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] done;
  logic [NDUT-1:0] full;
  logic [NDUT-1:0] empty;
  logic [NDUT-1:0] ovr;

  int         fStart [NDUT][MAXF];
  logic [7:0] fByte  [NDUT][MAXF];
  int         nf     [NDUT];
  logic       ovrModel [NDUT];
  int         cycleNum;
  int         checkCount;
  int         errorCount;

  uart_tx_ser #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_AW(2)) u0 (
    .clk(clk), .rst(rst), .tx_ready(tx_ready), .tx_data(tx_data), .ovr_clr(ovr_clr),
    .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_byte_done(done[0]),
    .fifo_full(full[0]), .fifo_empty(empty[0]), .ovr_flag(ovr[0]));

  uart_tx_ser #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_AW(2)) u1 (
    .clk(clk), .rst(rst), .tx_ready(tx_ready), .tx_data(tx_data), .ovr_clr(ovr_clr),
    .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_byte_done(done[1]),
    .fifo_full(full[1]), .fifo_empty(empty[1]), .ovr_flag(ovr[1]));

  uart_tx_ser #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .FIFO_AW(2)) u2 (
    .clk(clk), .rst(rst), .tx_ready(tx_ready), .tx_data(tx_data), .ovr_clr(ovr_clr),
    .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_byte_done(done[2]),
    .fifo_full(full[2]), .fifo_empty(empty[2]), .ovr_flag(ovr[2]));

  uart_tx_ser #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_AW(2)) u3 (
    .clk(clk), .rst(rst), .tx_ready(tx_ready), .tx_data(tx_data), .ovr_clr(ovr_clr),
    .uart_txd(txd[3]), .tx_busy(busy[3]), .tx_byte_done(done[3]),
    .fifo_full(full[3]), .fifo_empty(empty[3]), .ovr_flag(ovr[3]));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int penOf(int d);
    return (d == 1 || d == 2) ? 1 : 0;
  endfunction

  function automatic int oddOf(int d);
    return (d == 2) ? 1 : 0;
  endfunction

  function automatic int stopOf(int d);
    return (d == 3) ? 2 : 1;
  endfunction

  function automatic int frameLen(int d);
    return CPB * (9 + penOf(d) + stopOf(d));
  endfunction

  // Line level for bit slot idx of a frame: start, data LSB first, parity, stop.
  function automatic logic frameBit(int d, logic [7:0] b, int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (penOf(d) == 1 && idx == 9) begin
      ones = $countones(b);
      if (oddOf(d) == 1) return (ones % 2 == 0);
      return (ones % 2 == 1);
    end
    return 1'b1;
  endfunction

  function automatic logic expTxd(int d, int t);
    for (int k = 0; k < nf[d]; k++) begin
      if (t >= fStart[d][k] && t < fStart[d][k] + frameLen(d))
        return frameBit(d, fByte[d][k], (t - fStart[d][k]) / CPB);
    end
    return 1'b1;
  endfunction

  function automatic logic expDone(int d, int t);
    for (int k = 0; k < nf[d]; k++)
      if (t == fStart[d][k] + frameLen(d) - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic expBusy(int d, int t);
    for (int k = 0; k < nf[d]; k++)
      if (fStart[d][k] + frameLen(d) - 1 >= t) return 1'b1;
    return 1'b0;
  endfunction

  // Bytes accepted earlier whose frame has not yet begun are still queued.
  function automatic int expCount(int d, int t);
    int c;
    c = 0;
    for (int k = 0; k < nf[d]; k++)
      if (fStart[d][k] > t) c++;
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cycleNum);
    end
  endtask

  task automatic checkAll();
    int c;
    for (int d = 0; d < NDUT; d++) begin
      c = expCount(d, cycleNum);
      checkOutput($sformatf("txd[%0d]", d),   32'(txd[d]),   32'(expTxd(d, cycleNum)));
      checkOutput($sformatf("done[%0d]", d),  32'(done[d]),  32'(expDone(d, cycleNum)));
      checkOutput($sformatf("busy[%0d]", d),  32'(busy[d]),  32'(expBusy(d, cycleNum)));
      checkOutput($sformatf("empty[%0d]", d), 32'(empty[d]), 32'(c == 0));
      checkOutput($sformatf("full[%0d]", d),  32'(full[d]),  32'(c >= DEPTH));
      checkOutput($sformatf("ovr[%0d]", d),   32'(ovr[d]),   32'(ovrModel[d]));
    end
  endtask

  task automatic resetModel();
    for (int d = 0; d < NDUT; d++) begin
      nf[d] = 0;
      ovrModel[d] = 1'b0;
    end
  endtask

  // Schedule an accepted byte right after the previous frame, but no sooner than two cycles out.
  task automatic modelCycle(input logic ready, input logic [7:0] data, input logic clr);
    int c;
    int lastEnd;
    int s;
    for (int d = 0; d < NDUT; d++) begin
      c = expCount(d, cycleNum);
      if (ready && c >= DEPTH) begin
        ovrModel[d] = 1'b1;
      end else begin
        if (clr) ovrModel[d] = 1'b0;
        if (ready && nf[d] < MAXF) begin
          lastEnd = (nf[d] > 0) ? fStart[d][nf[d]-1] + frameLen(d) - 1 : -1000;
          s = (cycleNum + 2 > lastEnd + 1) ? cycleNum + 2 : lastEnd + 1;
          fStart[d][nf[d]] = s;
          fByte[d][nf[d]]  = data;
          nf[d]++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic [7:0] data, input logic clr);
    @(posedge clk);
    #1;
    cycleNum++;
    checkAll();
    tx_ready = ready;
    tx_data  = data;
    ovr_clr  = clr;
    modelCycle(ready, data, clr);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    int prob;
    checkCount = 0;
    errorCount = 0;
    cycleNum   = 0;
    rst      = 1'b0;
    tx_ready = 1'b0;
    tx_data  = 8'h00;
    ovr_clr  = 1'b0;
    resetModel();

    repeat (3) @(posedge clk);
    #1;
    checkAll();
    rst = 1'b1;

    applyStimulus(1'b1, 8'h55, 1'b0);
    idle(60);

    applyStimulus(1'b1, 8'h34, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b0);
    applyStimulus(1'b1, 8'h05, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    idle(4 * 44 + 20);

    applyStimulus(1'b1, 8'h07, 1'b0);
    idle(60);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    idle(60);

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
    idle(10);
    applyStimulus(1'b0, 8'h00, 1'b1);
    idle(5 * 44 + 20);

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
    applyStimulus(1'b1, 8'hBF, 1'b1);
    idle(30);
    applyStimulus(1'b0, 8'h00, 1'b1);
    idle(5 * 44 + 20);

    applyStimulus(1'b1, 8'h3C, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    idle(12);
    #3;
    rst = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("rst_txd[%0d]", d),   32'(txd[d]),   32'd1);
      checkOutput($sformatf("rst_empty[%0d]", d), 32'(empty[d]), 32'd1);
      checkOutput($sformatf("rst_busy[%0d]", d),  32'(busy[d]),  32'd0);
    end
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 8'h81, 1'b0);
    idle(60);

    for (int i = 0; i < 4000; i++) begin
      prob = ((i / 500) % 2 == 1) ? 20 : 3;
      applyStimulus($urandom_range(0, 99) < prob, 8'($urandom), $urandom_range(0, 99) < 3);
    end
    idle(300);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
